// File: rtl/mor1kx_rf_bypass_cappuccino.sv
// mor1kx_rf_bypass_cappuccino
// GPR file for the cappuccino pipeline. It stores writeback results and reads
// two operands on decode advance. It keeps the held execute-stage operands
// coherent with writebacks that land while execute is stalled.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   padv_decode_i     decode->execute advance, captures new operands
//   flush_i           clears execute-stage operands and held addresses
//   decode_rf{a,b}_adr_i  operand addresses at decode
//   wb_rf_we_i, wb_rfd_adr_i, wb_result_i  writeback write port
//   exec_rf{a,b}_o    execute-stage operands
//   exec_rf{a,b}_adr_o  addresses held for the execute-stage operands
//   rf_busy_o         register file unavailable (clear sequence running)
//
// Configuration macro: MOR1KX_RF_RESET_CLEAR_EN
//   Defined: after reset, every entry is zeroed, one entry per cycle, while
//   rf_busy_o is high. Undefined: no clear sequence and rf_busy_o is tied low.
module mor1kx_rf_bypass_cappuccino #(
    parameter int unsigned OPTION_OPERAND_WIDTH = 32,
    parameter int unsigned OPTION_RF_ADDR_WIDTH = 5
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            padv_decode_i,
    input  logic                            flush_i,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0] decode_rfa_adr_i,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0] decode_rfb_adr_i,
    input  logic                            wb_rf_we_i,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0] wb_rfd_adr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] wb_result_i,
    output logic [OPTION_OPERAND_WIDTH-1:0] exec_rfa_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] exec_rfb_o,
    output logic [OPTION_RF_ADDR_WIDTH-1:0] exec_rfa_adr_o,
    output logic [OPTION_RF_ADDR_WIDTH-1:0] exec_rfb_adr_o,
    output logic                            rf_busy_o
);

    localparam int unsigned W     = OPTION_OPERAND_WIDTH;
    localparam int unsigned AW    = OPTION_RF_ADDR_WIDTH;
    localparam int unsigned NREGS = 1 << AW;

    logic [W-1:0]  mem_q [NREGS];

    logic [W-1:0]  rfa_q, rfa_d;
    logic [W-1:0]  rfb_q, rfb_d;
    logic [AW-1:0] rfa_adr_q, rfa_adr_d;
    logic [AW-1:0] rfb_adr_q, rfb_adr_d;

    logic          rf_busy;
    logic          clr_we;
    logic [AW-1:0] clr_adr;

`ifdef MOR1KX_RF_RESET_CLEAR_EN
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;
    logic          busy_q;

    // Clear FSM state, counter and busy flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            busy_q    <= (state_d == ST_CLEAR);
        end
    end

    // Walk every entry once, then idle until the next reset
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clr_we    = 1'b0;
        if (state_q == ST_CLEAR) begin
            clr_we    = 1'b1;
            clr_cnt_d = clr_cnt_q + AW'(1);
            if (clr_cnt_q == {AW{1'b1}}) begin
                state_d = ST_IDLE;
            end
        end
    end

    assign clr_adr = clr_cnt_q;
    assign rf_busy = busy_q;
`else
    assign clr_we  = 1'b0;
    assign clr_adr = '0;
    assign rf_busy = 1'b0;
`endif

    // Writebacks are dropped while the clear sequence owns the array
    logic wb_we_ok;
    logic mem_we;
    assign wb_we_ok = wb_rf_we_i && !rf_busy;
    assign mem_we   = wb_we_ok && (wb_rfd_adr_i != '0);

    // Storage array; no reset so it maps onto a plain RAM
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[clr_adr] <= '0;
        end else if (mem_we) begin
            mem_q[wb_rfd_adr_i] <= wb_result_i;
        end
    end

    // Operand capture: flush > decode advance > late bypass of a held operand
    always_comb begin
        rfa_d     = rfa_q;
        rfb_d     = rfb_q;
        rfa_adr_d = rfa_adr_q;
        rfb_adr_d = rfb_adr_q;

        if (flush_i) begin
            rfa_d     = '0;
            rfb_d     = '0;
            rfa_adr_d = '0;
            rfb_adr_d = '0;
        end else if (padv_decode_i && !rf_busy) begin
            rfa_adr_d = decode_rfa_adr_i;
            rfb_adr_d = decode_rfb_adr_i;

            if (decode_rfa_adr_i == '0)
                rfa_d = '0;
            else if (wb_we_ok && (wb_rfd_adr_i == decode_rfa_adr_i))
                rfa_d = wb_result_i;
            else
                rfa_d = mem_q[decode_rfa_adr_i];

            if (decode_rfb_adr_i == '0)
                rfb_d = '0;
            else if (wb_we_ok && (wb_rfd_adr_i == decode_rfb_adr_i))
                rfb_d = wb_result_i;
            else
                rfb_d = mem_q[decode_rfb_adr_i];
        end else begin
            if (wb_we_ok && (rfa_adr_q != '0) && (wb_rfd_adr_i == rfa_adr_q))
                rfa_d = wb_result_i;
            if (wb_we_ok && (rfb_adr_q != '0) && (wb_rfd_adr_i == rfb_adr_q))
                rfb_d = wb_result_i;
        end
    end

    // Execute-stage operand registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rfa_q     <= '0;
            rfb_q     <= '0;
            rfa_adr_q <= '0;
            rfb_adr_q <= '0;
        end else begin
            rfa_q     <= rfa_d;
            rfb_q     <= rfb_d;
            rfa_adr_q <= rfa_adr_d;
            rfb_adr_q <= rfb_adr_d;
        end
    end

    assign exec_rfa_o     = rfa_q;
    assign exec_rfb_o     = rfb_q;
    assign exec_rfa_adr_o = rfa_adr_q;
    assign exec_rfb_adr_o = rfb_adr_q;
    assign rf_busy_o      = rf_busy;

endmodule

// File: tb/tb_mor1kx_rf_bypass_cappuccino.sv
// Directed bench for mor1kx_rf_bypass_cappuccino.
module tb_mor1kx_rf_bypass_cappuccino;

    localparam int unsigned W  = 32;
    localparam int unsigned AW = 5;
`ifdef MOR1KX_RF_RESET_CLEAR_EN
    localparam logic BUSY_RST = 1'b1;
`else
    localparam logic BUSY_RST = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          padv_decode_i;
    logic          flush_i;
    logic [AW-1:0] decode_rfa_adr_i;
    logic [AW-1:0] decode_rfb_adr_i;
    logic          wb_rf_we_i;
    logic [AW-1:0] wb_rfd_adr_i;
    logic [W-1:0]  wb_result_i;
    logic [W-1:0]  exec_rfa_o;
    logic [W-1:0]  exec_rfb_o;
    logic [AW-1:0] exec_rfa_adr_o;
    logic [AW-1:0] exec_rfb_adr_o;
    logic          rf_busy_o;

    int nvec = 0;
    int nerr = 0;

    mor1kx_rf_bypass_cappuccino #(
        .OPTION_OPERAND_WIDTH(W),
        .OPTION_RF_ADDR_WIDTH(AW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .padv_decode_i    (padv_decode_i),
        .flush_i          (flush_i),
        .decode_rfa_adr_i (decode_rfa_adr_i),
        .decode_rfb_adr_i (decode_rfb_adr_i),
        .wb_rf_we_i       (wb_rf_we_i),
        .wb_rfd_adr_i     (wb_rfd_adr_i),
        .wb_result_i      (wb_result_i),
        .exec_rfa_o       (exec_rfa_o),
        .exec_rfb_o       (exec_rfb_o),
        .exec_rfa_adr_o   (exec_rfa_adr_o),
        .exec_rfb_adr_o   (exec_rfb_adr_o),
        .rf_busy_o        (rf_busy_o)
    );

    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1 time unit later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        padv_decode_i    = 1'b0;
        flush_i          = 1'b0;
        wb_rf_we_i       = 1'b0;
        decode_rfa_adr_i = '0;
        decode_rfb_adr_i = '0;
        wb_rfd_adr_i     = '0;
        wb_result_i      = '0;
    endtask

    task automatic wb(input logic [AW-1:0] adr, input logic [W-1:0] data);
        wb_rf_we_i   = 1'b1;
        wb_rfd_adr_i = adr;
        wb_result_i  = data;
    endtask

    task automatic padv(input logic [AW-1:0] a, input logic [AW-1:0] b);
        padv_decode_i    = 1'b1;
        decode_rfa_adr_i = a;
        decode_rfb_adr_i = b;
    endtask

    // Bounded wait for the clear sequence; returns the number of busy edges
    task automatic wait_not_busy(output int n);
        n = 0;
        while (rf_busy_o && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        int n;
        idle();
        rst = 1'b1;
        #3;
        nvec++; if (exec_rfa_o !== '0) begin nerr++; $display("FAIL reset_rfa: got %h exp 0", exec_rfa_o); end
        nvec++; if (exec_rfb_o !== '0) begin nerr++; $display("FAIL reset_rfb: got %h exp 0", exec_rfb_o); end
        nvec++; if (exec_rfa_adr_o !== '0) begin nerr++; $display("FAIL reset_rfa_adr: got %h exp 0", exec_rfa_adr_o); end
        nvec++; if (exec_rfb_adr_o !== '0) begin nerr++; $display("FAIL reset_rfb_adr: got %h exp 0", exec_rfb_adr_o); end
        nvec++; if (rf_busy_o !== BUSY_RST) begin nerr++; $display("FAIL reset_busy: got %b exp %b", rf_busy_o, BUSY_RST); end
        tick();
        tick();
        rst = 1'b0;
`ifdef MOR1KX_RF_RESET_CLEAR_EN
        // Writes during the clear sequence must be dropped
        wb(5'd9, 32'h5555_5555);
        wait_not_busy(n);
        idle();
        nvec++; if (n != 32) begin nerr++; $display("FAIL clear_busy_cycles: got %0d exp 32", n); end
`else
        n = 0;
        tick();
`endif
    endtask

`ifdef MOR1KX_RF_RESET_CLEAR_EN
    task automatic test_clear();
        for (int r = 1; r < 32; r += 2) begin
            padv(AW'(r), AW'(r + 1));
            tick();
            idle();
            nvec++; if (exec_rfa_o !== '0) begin nerr++; $display("FAIL clear_r%0d: got %h exp 0", r, exec_rfa_o); end
            if (r + 1 < 32) begin
                nvec++; if (exec_rfb_o !== '0) begin nerr++; $display("FAIL clear_r%0d: got %h exp 0", r + 1, exec_rfb_o); end
            end
        end
    endtask
`endif

    task automatic test_write_read();
        wb(5'd5, 32'hDEAD_BEEF);
        tick();
        idle();
        padv(5'd5, 5'd0);
        tick();
        idle();
        nvec++; if (exec_rfa_o !== 32'hDEAD_BEEF) begin nerr++; $display("FAIL read_r5: got %h exp deadbeef", exec_rfa_o); end
        nvec++; if (exec_rfb_o !== 32'h0) begin nerr++; $display("FAIL read_r0_b: got %h exp 0", exec_rfb_o); end
        nvec++; if (exec_rfa_adr_o !== 5'd5) begin nerr++; $display("FAIL read_adr_a: got %0d exp 5", exec_rfa_adr_o); end
    endtask

    task automatic test_write_through();
        wb(5'd7, 32'h1234_5678);
        padv(5'd7, 5'd7);
        tick();
        idle();
        nvec++; if (exec_rfa_o !== 32'h1234_5678) begin nerr++; $display("FAIL wthru_a: got %h exp 12345678", exec_rfa_o); end
        nvec++; if (exec_rfb_o !== 32'h1234_5678) begin nerr++; $display("FAIL wthru_b: got %h exp 12345678", exec_rfb_o); end
        nvec++; if (exec_rfb_adr_o !== 5'd7) begin nerr++; $display("FAIL wthru_adr_b: got %0d exp 7", exec_rfb_adr_o); end
    endtask

    task automatic test_late_bypass();
        wb(5'd3, 32'h1111_1111);
        tick();
        idle();
        padv(5'd3, 5'd5);
        tick();
        idle();
        nvec++; if (exec_rfa_o !== 32'h1111_1111) begin nerr++; $display("FAIL lb_capture: got %h exp 11111111", exec_rfa_o); end
        wb(5'd3, 32'hA5A5_A5A5);
        tick();
        idle();
        nvec++; if (exec_rfa_o !== 32'hA5A5_A5A5) begin nerr++; $display("FAIL lb_update_a: got %h exp a5a5a5a5", exec_rfa_o); end
        nvec++; if (exec_rfb_o !== 32'hDEAD_BEEF) begin nerr++; $display("FAIL lb_other_b: got %h exp deadbeef", exec_rfb_o); end
        wb(5'd4, 32'h0BAD_F00D);
        tick();
        idle();
        nvec++; if (exec_rfa_o !== 32'hA5A5_A5A5) begin nerr++; $display("FAIL lb_nomatch: got %h exp a5a5a5a5", exec_rfa_o); end
        // Both held operands pick up the same write
        padv(5'd4, 5'd4);
        tick();
        idle();
        nvec++; if (exec_rfa_o !== 32'h0BAD_F00D) begin nerr++; $display("FAIL lb_r4_read: got %h exp 0badf00d", exec_rfa_o); end
        wb(5'd4, 32'hCAFE_BABE);
        tick();
        idle();
        nvec++; if (exec_rfa_o !== 32'hCAFE_BABE) begin nerr++; $display("FAIL lb_dual_a: got %h exp cafebabe", exec_rfa_o); end
        nvec++; if (exec_rfb_o !== 32'hCAFE_BABE) begin nerr++; $display("FAIL lb_dual_b: got %h exp cafebabe", exec_rfb_o); end
    endtask

    task automatic test_r0();
        wb(5'd0, 32'hFFFF_FFFF);
        tick();
        idle();
        wb(5'd0, 32'hFFFF_FFFF);
        padv(5'd0, 5'd0);
        tick();
        idle();
        nvec++; if (exec_rfa_o !== 32'h0) begin nerr++; $display("FAIL r0_a: got %h exp 0", exec_rfa_o); end
        nvec++; if (exec_rfb_o !== 32'h0) begin nerr++; $display("FAIL r0_b: got %h exp 0", exec_rfb_o); end
        wb(5'd0, 32'hFFFF_FFFF);
        tick();
        idle();
        nvec++; if (exec_rfa_o !== 32'h0) begin nerr++; $display("FAIL r0_hold: got %h exp 0", exec_rfa_o); end
    endtask

    task automatic test_flush();
        padv(5'd5, 5'd7);
        wb(5'd9, 32'h9999_9999);
        flush_i = 1'b1;
        tick();
        idle();
        nvec++; if (exec_rfa_o !== '0) begin nerr++; $display("FAIL flush_rfa: got %h exp 0", exec_rfa_o); end
        nvec++; if (exec_rfb_o !== '0) begin nerr++; $display("FAIL flush_rfb: got %h exp 0", exec_rfb_o); end
        nvec++; if (exec_rfa_adr_o !== '0) begin nerr++; $display("FAIL flush_adr_a: got %0d exp 0", exec_rfa_adr_o); end
        nvec++; if (exec_rfb_adr_o !== '0) begin nerr++; $display("FAIL flush_adr_b: got %0d exp 0", exec_rfb_adr_o); end
        padv(5'd9, 5'd3);
        tick();
        idle();
        nvec++; if (exec_rfa_o !== 32'h9999_9999) begin nerr++; $display("FAIL flush_wr_kept: got %h exp 99999999", exec_rfa_o); end
        nvec++; if (exec_rfb_o !== 32'hA5A5_A5A5) begin nerr++; $display("FAIL flush_rd_r3: got %h exp a5a5a5a5", exec_rfb_o); end
    endtask

    task automatic test_back_to_back();
        padv(5'd5, 5'd7);
        tick();
        nvec++; if (exec_rfa_o !== 32'hDEAD_BEEF) begin nerr++; $display("FAIL b2b_1a: got %h exp deadbeef", exec_rfa_o); end
        nvec++; if (exec_rfb_o !== 32'h1234_5678) begin nerr++; $display("FAIL b2b_1b: got %h exp 12345678", exec_rfb_o); end
        padv(5'd7, 5'd9);
        wb(5'd5, 32'h0000_0055);
        tick();
        wb_rf_we_i = 1'b0;
        nvec++; if (exec_rfa_o !== 32'h1234_5678) begin nerr++; $display("FAIL b2b_2a: got %h exp 12345678", exec_rfa_o); end
        nvec++; if (exec_rfb_o !== 32'h9999_9999) begin nerr++; $display("FAIL b2b_2b: got %h exp 99999999", exec_rfb_o); end
        padv(5'd5, 5'd4);
        tick();
        idle();
        nvec++; if (exec_rfa_o !== 32'h0000_0055) begin nerr++; $display("FAIL b2b_3a: got %h exp 00000055", exec_rfa_o); end
        nvec++; if (exec_rfb_o !== 32'hCAFE_BABE) begin nerr++; $display("FAIL b2b_3b: got %h exp cafebabe", exec_rfb_o); end
    endtask

    task automatic test_async_reset();
        int n;
        padv(5'd7, 5'd5);
        tick();
        idle();
        #2;
        rst = 1'b1;
        #1;
        nvec++; if (exec_rfa_o !== '0) begin nerr++; $display("FAIL async_rst_rfa: got %h exp 0", exec_rfa_o); end
        nvec++; if (exec_rfa_adr_o !== '0) begin nerr++; $display("FAIL async_rst_adr: got %0d exp 0", exec_rfa_adr_o); end
        nvec++; if (rf_busy_o !== BUSY_RST) begin nerr++; $display("FAIL async_rst_busy: got %b exp %b", rf_busy_o, BUSY_RST); end
        tick();
        rst = 1'b0;
        wait_not_busy(n);
        nvec++; if (rf_busy_o !== 1'b0) begin nerr++; $display("FAIL async_rst_busy_drop: got %b exp 0 after %0d cycles", rf_busy_o, n); end
    endtask

    initial begin
        test_reset();
`ifdef MOR1KX_RF_RESET_CLEAR_EN
        test_clear();
`endif
        test_write_read();
        test_write_through();
        test_late_bypass();
        test_r0();
        test_flush();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
